// File: rtl/pb_pkg.sv
// Shared types for the button event queue: FSM state encoding and event width.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Queued event layout is {long, code}, so one bit wider than the button index.
    function automatic int ev_width(input int num_pb);
        return $clog2(num_pb) + 1;
    endfunction

endpackage

// File: rtl/pb_event_fifo.sv
// First-word-fall-through FIFO holding press events; head is valid whenever non-empty.
module pb_event_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH+1))'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is not reset; the empty gating on head hides stale entries.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pb_event_queue.sv
// Turns debounced button levels into short/long press events reported on release,
// buffered in a small FWFT queue for the game sequencer.
module pb_event_queue
    import pb_pkg::*;
#(
    parameter int NUM_PB      = 4,
    parameter int LONG_CYCLES = 25_000_000,
    parameter int DEPTH       = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_PB-1:0]         pb_state,
    input  logic                      ev_ready,
    output logic                      ev_valid,
    output logic [$clog2(NUM_PB)-1:0] ev_code,
    output logic                      ev_long,
    output logic                      hold_active,
    output logic [$clog2(NUM_PB)-1:0] hold_code,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    localparam int CW    = $clog2(NUM_PB);
    localparam int EV_W  = ev_width(NUM_PB);
    localparam int CNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

    function automatic logic [CW-1:0] lowest_set(input logic [NUM_PB-1:0] v);
        lowest_set = '0;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = CW'(i);
        end
    endfunction

    state_t                     state;
    logic [CW-1:0]              code_q;
    logic [CNT_W-1:0]           hold_cnt;
    logic [CNT_W-1:0]           cnt_next;
    logic                       released;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [EV_W-1:0]            push_data;
    logic [EV_W-1:0]            head_data;

    // The release cycle itself counts towards the hold, hence the look-ahead value.
    assign cnt_next  = (hold_cnt == LONG_MAX) ? LONG_MAX : hold_cnt + CNT_W'(1);
    assign released  = (state == HELD) && !pb_state[code_q];
    assign push_data = {cnt_next >= LONG_MAX, code_q};
    assign pop       = ev_ready && (count != '0);

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WAIT_REL;
            code_q   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pb_state) begin
                        code_q   <= lowest_set(pb_state);
                        hold_cnt <= '0;
                        state    <= HELD;
                    end
                end
                HELD: begin
                    if (released) state    <= (|pb_state) ? WAIT_REL : IDLE;
                    else          hold_cnt <= cnt_next;
                end
                WAIT_REL: begin
                    if (!(|pb_state)) state <= IDLE;
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

    // A drop and a clear in the same cycle leave the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                        overflow <= 1'b0;
        else if (released && full && !pop)   overflow <= 1'b1;
        else if (overflow_clr)               overflow <= 1'b0;
    end

    pb_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (released),
        .push_data (push_data),
        .pop       (pop),
        .head      (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign ev_valid    = !empty;
    assign ev_code     = head_data[CW-1:0];
    assign ev_long     = head_data[CW];
    assign hold_active = (state == HELD);
    assign hold_code   = code_q;

endmodule

// File: tb/tb_pb_event_queue.sv
// Randomised bench for pb_event_queue: press episodes are described by button,
// hold length and an optional second button; a queue model predicts the event stream.
module tb_pb_event_queue;

    localparam int NUM_PB      = 4;
    localparam int LONG_CYCLES = 8;
    localparam int DEPTH       = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] pb_state = '0;
    logic       ev_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_long;
    logic       hold_active;
    logic [1:0] hold_code;
    logic       overflow;

    always #5 clock = ~clock;

    pb_event_queue #(
        .NUM_PB      (NUM_PB),
        .LONG_CYCLES (LONG_CYCLES),
        .DEPTH       (DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pb_state     (pb_state),
        .ev_ready     (ev_ready),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .ev_long      (ev_long),
        .hold_active  (hold_active),
        .hold_code    (hold_code),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    typedef struct {
        int code;
        bit lng;
    } ev_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t sb[$];
    bit  ovf_m = 1'b0;

    // Per-cycle facts published by the stimulus for the monitor.
    bit  rel_now   = 1'b0;
    int  rel_code  = 0;
    bit  rel_long  = 1'b0;
    bit  exp_hold  = 1'b0;
    int  exp_hcode = 0;
    int  ready_mode = 1;   // 0 never, 1 always, 2 random, 3 only on the release cycle
    int  clr_mode   = 0;   // 0 never, 1 random, 2 on the release cycle

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Monitor: compares outputs mid-cycle, then advances the queue model across the coming edge.
    always @(negedge clock) begin
        bit  drop;
        ev_t e;
        if (!reset_n) begin
            sb.delete();
            ovf_m = 1'b0;
            check("rst_ev_valid", ev_valid, 0);
            check("rst_ev_code", ev_code, 0);
            check("rst_ev_long", ev_long, 0);
            check("rst_hold_active", hold_active, 0);
            check("rst_hold_code", hold_code, 0);
            check("rst_overflow", overflow, 0);
        end else begin
            check("ev_valid", ev_valid, sb.size() != 0);
            check("overflow", overflow, ovf_m);
            check("hold_active", hold_active, exp_hold);
            if (exp_hold) check("hold_code", hold_code, exp_hcode);
            if (sb.size() != 0 && ev_ready) begin
                e = sb.pop_front();
                check("ev_code", ev_code, e.code);
                check("ev_long", ev_long, e.lng);
            end
            drop = 1'b0;
            if (rel_now) begin
                if (sb.size() < DEPTH) sb.push_back('{rel_code, rel_long});
                else                   drop = 1'b1;
            end
            if (drop)              ovf_m = 1'b1;
            else if (overflow_clr) ovf_m = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic pick_ready(input bit at_rel);
        case (ready_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return at_rel;
        endcase
    endfunction

    function automatic logic pick_clr(input bit at_rel);
        case (clr_mode)
            1:       return ($urandom_range(0, 19) == 0);
            2:       return at_rel;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pb_state     = '0;
            rel_now      = 1'b0;
            exp_hold     = 1'b0;
            ev_ready     = pick_ready(1'b0);
            overflow_clr = pick_clr(1'b0);
            tick();
        end
    endtask

    // Button p is held for d cycles from an idle start; button xb (or none if < 0)
    // is held from offset xoff for xdur cycles. Exactly one event (p, d >= LONG) results.
    task automatic episode(input int p, input int d, input int xb, input int xoff,
                           input int xdur, input int gap);
        int         len;
        logic [3:0] v;
        len = d;
        if (xb >= 0 && xoff + xdur > len) len = xoff + xdur;
        for (int t = 0; t < len + gap; t++) begin
            v = '0;
            if (t < d) v[p] = 1'b1;
            if (xb >= 0 && t >= xoff && t < xoff + xdur) v[xb] = 1'b1;
            pb_state     = v;
            rel_now      = (t == d);
            rel_code     = p;
            rel_long     = (d >= LONG_CYCLES);
            exp_hold     = (t >= 1 && t <= d);
            exp_hcode    = p;
            ev_ready     = pick_ready(t == d);
            overflow_clr = pick_clr(t == d);
            tick();
        end
        rel_now  = 1'b0;
        exp_hold = 1'b0;
    endtask

    task automatic random_episode();
        int p, d, xb, xoff, xdur;
        p    = $urandom_range(0, 3);
        d    = $urandom_range(1, 12);
        xb   = -1;
        xoff = 0;
        xdur = 0;
        if ($urandom_range(0, 1) == 1) begin
            xoff = $urandom_range(0, d);
            if (xoff == 0 && p == 3) xoff = 1;
            if (xoff == 0) begin
                xb = $urandom_range(p + 1, 3);
            end else begin
                xb = $urandom_range(0, 2);
                if (xb >= p) xb++;
            end
            xdur = $urandom_range(1, 10);
        end
        episode(p, d, xb, xoff, xdur, $urandom_range(1, 3));
    endtask

    initial begin
        // Button 1 held through reset deassertion must not produce an event.
        #2;
        pb_state = 4'b0010;
        reset_n  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        idle(3);

        ready_mode = 1;
        clr_mode   = 0;
        episode(2, 5, -1, 0, 0, 2);
        episode(1, 8, -1, 0, 0, 1);
        episode(3, 7, -1, 0, 0, 2);
        episode(0, 4, 3, 0, 9, 2);
        episode(1, 1, -1, 0, 0, 1);
        episode(2, 20, 0, 3, 4, 2);
        idle(3);

        // Fill with the consumer stalled, then drop two; clear collides with the last drop.
        ready_mode = 0;
        for (int i = 0; i < 5; i++) random_episode();
        clr_mode = 2;
        random_episode();
        clr_mode = 0;
        idle(1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        idle(1);
        // Push and pop in the same cycle while full.
        ready_mode = 3;
        episode(3, 9, -1, 0, 0, 2);
        ready_mode = 1;
        idle(6);

        clr_mode = 1;
        for (int i = 0; i < 80; i++) begin
            ready_mode = $urandom_range(0, 3);
            random_episode();
        end
        clr_mode   = 0;
        ready_mode = 1;
        idle(6);

        // Reset mid-hold with three events queued.
        ready_mode = 0;
        for (int i = 0; i < 3; i++) random_episode();
        ev_ready  = 1'b0;
        pb_state  = 4'b0100;
        exp_hcode = 2;
        for (int t = 0; t < 4; t++) begin
            exp_hold = (t >= 1);
            tick();
        end
        reset_n  = 1'b0;
        exp_hold = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        ready_mode = 1;
        idle(3);
        episode(3, 9, -1, 0, 0, 2);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
